// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing,
// kept here so a transmitter can reuse them.
`timescale 1ns/1ps
package uart_pkg;

   // 25 MHz clk / 115200 baud
   localparam int UART_CLKS_PER_BIT = 217;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 1
// so an idle-high line never shows a false edge coming out of reset.
`timescale 1ns/1ps
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit midpoint qualification, mid-bit data sampling,
// sticky frame-error / overrun flags and a single-entry output register.
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy,
   output logic [2:0] dbg_state
);

   // Output handshake: rx_valid high means rx_data holds an unread byte; the
   // consumer pulses rd_ack for one cycle, which clears rx_valid, frame_err and
   // overrun on the next edge. A delivery or frame-error set in that same cycle
   // takes priority over the clear.

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic rxd_s;

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             deliver_q, deliver_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             fe_set;

   sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rxd),
      .q     (rxd_s)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      deliver_d = 1'b0;
      fe_set    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            if (!rxd_s) state_d = ST_START;
         end

         // A start bit must still be low at its midpoint; shorter pulses are noise.
         ST_START: begin
            if (cnt_q == CNT_MID) begin
               cnt_d   = '0;
               state_d = rxd_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d            = '0;
               shift_d[bit_idx_q] = rxd_s;
               if (bit_idx_q == 3'd7) state_d = ST_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Leaving at the stop-bit midpoint gives half a bit of slack before
         // a back-to-back start bit can arrive.
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rxd_s) begin
                  deliver_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  fe_set  = 1'b1;
                  state_d = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_BREAK: begin
            if (rxd_s) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_data_d   = deliver_q ? shift_q : rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;

      if (rd_ack) begin
         rx_valid_d  = 1'b0;
         overrun_d   = 1'b0;
         frame_err_d = 1'b0;
      end
      if (deliver_q) begin
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rd_ack) overrun_d = 1'b1;
      end
      if (fe_set) frame_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         deliver_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         deliver_q   <= deliver_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217, meaning clk cycles per UART bit (25 MHz / 115200 baud).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic rising-edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port rxd, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port rd_ack, input, 1, one-cycle strobe: consumer has taken rx_data.
REQ-006 The block SHALL have port rx_data, output, 8, last received byte.
REQ-007 The block SHALL have port rx_valid, output, 1, rx_data holds an unread byte.
REQ-008 The block SHALL have port frame_err, output, 1, sticky: a stop bit sampled low.
REQ-009 The block SHALL have port overrun, output, 1, sticky: an unread byte was overwritten.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value rxd_s.
REQ-012 States SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: rxd_s==0 -> START; bit counter and baud counter cleared.
REQ-014 START: at baud count (CLKS_PER_BIT-1)/2 (108 at default), rxd_s==0 -> DATA with baud counter cleared; rxd_s==1 -> IDLE (glitch rejected, no flags).
REQ-015 DATA: at baud count CLKS_PER_BIT-1, sample rxd_s into shift register bit [bit_idx] and clear the baud counter; after bit_idx 7 -> STOP.
REQ-016 STOP: at baud count CLKS_PER_BIT-1, rxd_s==1 -> deliver byte, IDLE; rxd_s==0 -> set frame_err, discard byte, BREAK.
REQ-017 BREAK: stay until rxd_s==1, then IDLE.
REQ-018 Delivery: rx_data <= shift register and rx_valid <= 1 in the cycle after the stop sample.
REQ-019 Delivery while rx_valid==1 without rd_ack in the same cycle SHALL set overrun; the new byte overwrites rx_data.
REQ-020 rd_ack SHALL clear rx_valid, frame_err and overrun the following cycle.
REQ-021 rd_ack coincident with delivery: the new byte is stored, rx_valid stays 1, overrun is not set.
REQ-022 rd_ack coincident with a frame_err set event: the set wins.
REQ-023 rd_ack while rx_valid==0 SHALL have no effect other than the flag clearing in REQ-020.
REQ-024 Back-to-back frames (next start bit immediately after the stop bit) SHALL be received without loss, because IDLE is re-entered at the stop-bit midpoint.
REQ-025 Baud counter width SHALL be $clog2(CLKS_PER_BIT); the bit index SHALL be 3 bits, with no wrap past 7.

Reset
REQ-026 reset SHALL force state IDLE, counters 0, shift register 0x00, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, busy 0, and synchronizer flops 1.
REQ-027 reset asserted mid-frame SHALL abandon the frame with no delivery; reception restarts on the next falling edge after reset deasserts.

Structure
REQ-028 The state encoding and the default CLKS_PER_BIT SHALL live in shared package uart_pkg, for reuse by the future uart_tx.
REQ-029 The 2-flop synchronizer SHALL be sub-module sync2; all other logic is flat in uart_rx.

Verification
REQ-030 The bench SHALL send 0x34 at 8680 ns/bit, 25 MHz clk -> rx_data=0x34, rx_valid=1, frame_err=0, overrun=0.
REQ-031 The bench SHALL send 0x2A then 0x39 back-to-back, acking each byte -> two deliveries (0x2A, 0x39), no flags.
REQ-032 The bench SHALL pulse rxd low for 50 clk -> busy pulses, rx_valid stays 0, no flags, and the state returns to IDLE.
REQ-033 The bench SHALL send 0x35 with the stop bit forced low, then idle -> frame_err=1, rx_valid=0, busy held until rxd high; rd_ack clears frame_err.
REQ-034 The bench SHALL send 0x30 then 0x33 with no rd_ack -> rx_data=0x33, overrun=1; a single rd_ack clears rx_valid and overrun.
REQ-035 The bench SHALL assert reset during bit 4 of 0x2F, then send 0x39 -> no 0x2F delivery; rx_data=0x39.
